// File: rtl/alu_mc_pkg.sv
// alu_defs: shared definitions for the alu_mc execution unit.
//   WORD        default datapath width (matches `WORD in the legacy code)
//   WORD_CNTW   default iteration-counter width for the multiplier
//   OP_*        5-bit operation codes; anything above OP_LAST is undefined
//   state_t     alu_mc control states
package alu_defs;

    localparam int unsigned WORD      = 16;
    localparam int unsigned WORD_CNTW = 4;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_NOT  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8;
    localparam logic [4:0] OP_SLT  = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;
    localparam logic [4:0] OP_LAST = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_defined(input logic [4:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_mc_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier datapath, sequenced by alu_mc.
//   clk, reset  clock and synchronous active-high reset
//   start       load mcand=x, mplier=y, clear acc and cnt
//   step        perform one shift-add iteration
//   x, y        operands, captured on start
//   done        high during the final iteration (cnt == WIDTH-1 while stepping)
//   product     accumulator including the current iteration's add; valid with done
// Always runs WIDTH iterations; there is no early exit on a zero multiplier.
module alu_mul_iter
    import alu_defs::*;
#(
    parameter int unsigned WIDTH = WORD,
    parameter int unsigned CNTW  = WORD_CNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNTW-1:0]  cnt;

    // Bits carried past WIDTH are dropped: the product is modulo 2^WIDTH.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= x;
            mplier <= y;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign done    = step && (cnt == CNTW'(WIDTH - 1));
    assign product = acc_next;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: clocked, handshaked ALU responder between issue and writeback.
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   request handshake; request is op, x, y
//   out_valid/out_ready result handshake; result is z, z_zero, bad_op
//   z                   result word (modulo 2^WIDTH)
//   z_zero              z == 0
//   bad_op              op was not a defined encoding (z forced to 0)
// Single-cycle ops return one cycle after accept; MUL returns WIDTH+1 cycles
// after accept. The result is held until taken; one request in flight at most.
module alu_mc
    import alu_defs::*;
#(
    parameter int unsigned WIDTH = WORD,
    parameter int unsigned CNTW  = WORD_CNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             z_zero,
    output logic             bad_op
);

    state_t state;
    state_t state_next;

    logic             accept;
    logic             mul_start;
    logic             mul_step;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             load_z;
    logic [WIDTH:0]   sc_result;

    // Returns {bad, result}. Shifts use only y[3:0].
    function automatic logic [WIDTH:0] single_cycle(
        input logic [4:0]       f_op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        logic             bad;
        r   = '0;
        bad = 1'b0;
        case (f_op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_SHL:  r = a << b[3:0];
            OP_SHR:  r = a >> b[3:0];
            OP_SRA:  r = WIDTH'($signed(a) >>> b[3:0]);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL:  r = '0;
            default: bad = !op_defined(f_op);
        endcase
        return {bad, r};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign sc_result = single_cycle(op, x, y);

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        load_z     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mul_start  = 1'b1;
                        state_next = MUL;
                    end else begin
                        load_z     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE here means a new request can only be
                // accepted on the edge after the result is taken.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mul_step = (state == MUL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z      <= '0;
            bad_op <= 1'b0;
        end else if (load_z) begin
            z      <= sc_result[WIDTH-1:0];
            bad_op <= sc_result[WIDTH];
        end else if (mul_done) begin
            z      <= mul_product;
            bad_op <= 1'b0;
        end
    end

    assign z_zero = (z == '0);

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .step    (mul_step),
        .x       (x),
        .y       (y),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule
